// File: rtl/cpu_mem_pkg.sv
// Shared encodings and types for the Memory stage of the 16-bit CPU pipeline.
// Keeps memory-mode decoding in one place so every consumer classifies identically.
package cpu_mem_pkg;

  localparam logic [1:0] MM_NONE = 2'b00;
  localparam logic [1:0] MM_LOAD = 2'b01;

  localparam int TIMEOUT_DEFAULT = 64;

  typedef enum logic {
    IDLE,
    ACCESS
  } mem_state_t;

  typedef enum logic [1:0] {
    ACC_NONE,
    ACC_LOAD,
    ACC_STORE
  } access_kind_t;

  // Store enable outranks the memory mode; reserved modes behave like no access.
  function automatic access_kind_t classify_access(input logic       valid,
                                                   input logic       wm,
                                                   input logic [1:0] mm);
    access_kind_t kind;
    kind = ACC_NONE;
    if (valid) begin
      if (wm)                kind = ACC_STORE;
      else if (mm == MM_LOAD) kind = ACC_LOAD;
    end
    return kind;
  endfunction

endpackage

// File: rtl/mem_timeout_counter.sv
// Cycle counter for an outstanding memory access; flags the last permitted cycle.
// Clear dominates enable so the count always starts from zero on a new access.
module mem_timeout_counter
  import cpu_mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count_q;

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst)         count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_q + CNT_W'(1);
  end

  assign expired = enable && (count_q == LAST);

endmodule

// File: rtl/memory_access_stage.sv
// Memory stage: issues one request/acknowledge access per load or store, stalls
// upstream while it is outstanding, and registers results for the writeback register.
module memory_access_stage
  import cpu_mem_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_W   = 4,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid_in,
  input  logic              wbs_in,
  input  logic [1:0]        mm_in,
  input  logic              wm_in,
  input  logic              reg_write_in,
  input  logic [DATA_W-1:0] alu_result_in,
  input  logic [DATA_W-1:0] mem_data_in,
  input  logic [REG_W-1:0]  reg_dest_in,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [DATA_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              wb_valid_o,
  output logic [DATA_W-1:0] wb_data_o,
  output logic [REG_W-1:0]  wb_reg_dest_o,
  output logic              wb_reg_write_o,
  output logic              wb_wbs_o,
  output logic              mem_err_o
);

  mem_state_t   state_q;
  access_kind_t kind;

  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic [REG_W-1:0]  dest_q;
  logic              reg_write_q;
  logic              wbs_q;

  logic in_access;
  logic expired;
  logic done;
  logic timed_out;

  assign kind      = classify_access(ex_valid_in, wm_in, mm_in);
  assign in_access = (state_q == ACCESS);

  // A timeout completes the access like an ack; a real ack in the same cycle wins.
  assign done      = in_access && (mem_ack_i || expired);
  assign timed_out = in_access && expired && !mem_ack_i;

  mem_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (!in_access),
    .enable  (in_access),
    .expired (expired)
  );

  // NOTE: every signal driven here gets a default first so no latch is inferred.
  always_comb begin
    stall_o = 1'b0;
    if (!rst) begin
      if (in_access) stall_o = !done;
      else           stall_o = (kind != ACC_NONE);
    end
  end

  assign mem_req_o   = in_access;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      we_q           <= 1'b0;
      dest_q         <= '0;
      reg_write_q    <= 1'b0;
      wbs_q          <= 1'b0;
      wb_valid_o     <= 1'b0;
      wb_data_o      <= '0;
      wb_reg_dest_o  <= '0;
      wb_reg_write_o <= 1'b0;
      wb_wbs_o       <= 1'b0;
      mem_err_o      <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      case (state_q)
        IDLE: begin
          if (kind == ACC_NONE) begin
            if (ex_valid_in) begin
              wb_valid_o     <= 1'b1;
              wb_data_o      <= alu_result_in;
              wb_reg_dest_o  <= reg_dest_in;
              wb_reg_write_o <= reg_write_in;
              wb_wbs_o       <= wbs_in;
            end
          end else begin
            state_q     <= ACCESS;
            addr_q      <= alu_result_in;
            wdata_q     <= mem_data_in;
            we_q        <= (kind == ACC_STORE);
            dest_q      <= reg_dest_in;
            reg_write_q <= reg_write_in;
            wbs_q       <= wbs_in;
          end
        end
        ACCESS: begin
          if (done) begin
            state_q       <= IDLE;
            wb_valid_o    <= 1'b1;
            wb_reg_dest_o <= dest_q;
            wb_wbs_o      <= wbs_q;
            if (we_q) begin
              // Stores report their address so the writeback stage sees a defined value.
              wb_data_o      <= addr_q;
              wb_reg_write_o <= 1'b0;
            end else begin
              wb_data_o      <= timed_out ? '0 : mem_rdata_i;
              wb_reg_write_o <= reg_write_q;
            end
            if (timed_out) mem_err_o <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with TIMEOUT=4 and hand-computed expectations.
module tb_memory_access_stage;

  localparam int DATA_W = 16;
  localparam int REG_W  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              ex_valid_in;
  logic              wbs_in;
  logic [1:0]        mm_in;
  logic              wm_in;
  logic              reg_write_in;
  logic [DATA_W-1:0] alu_result_in;
  logic [DATA_W-1:0] mem_data_in;
  logic [REG_W-1:0]  reg_dest_in;
  logic              stall_o;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              mem_ack_i;
  logic              wb_valid_o;
  logic [DATA_W-1:0] wb_data_o;
  logic [REG_W-1:0]  wb_reg_dest_o;
  logic              wb_reg_write_o;
  logic              wb_wbs_o;
  logic              mem_err_o;

  int n_checks = 0;
  int n_pass   = 0;

  memory_access_stage #(
    .DATA_W  (DATA_W),
    .REG_W   (REG_W),
    .TIMEOUT (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid_in    (ex_valid_in),
    .wbs_in         (wbs_in),
    .mm_in          (mm_in),
    .wm_in          (wm_in),
    .reg_write_in   (reg_write_in),
    .alu_result_in  (alu_result_in),
    .mem_data_in    (mem_data_in),
    .reg_dest_in    (reg_dest_in),
    .stall_o        (stall_o),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wdata_o    (mem_wdata_o),
    .mem_rdata_i    (mem_rdata_i),
    .mem_ack_i      (mem_ack_i),
    .wb_valid_o     (wb_valid_o),
    .wb_data_o      (wb_data_o),
    .wb_reg_dest_o  (wb_reg_dest_o),
    .wb_reg_write_o (wb_reg_write_o),
    .wb_wbs_o       (wb_wbs_o),
    .mem_err_o      (mem_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid_in   = 1'b0;
    wbs_in        = 1'b0;
    mm_in         = 2'b00;
    wm_in         = 1'b0;
    reg_write_in  = 1'b0;
    alu_result_in = '0;
    mem_data_in   = '0;
    reg_dest_in   = '0;
  endtask

  task automatic drive(input logic wm, input logic [1:0] mm, input logic [15:0] alu,
                       input logic [15:0] wdata, input logic [3:0] dest, input logic rw,
                       input logic wbs);
    ex_valid_in   = 1'b1;
    wm_in         = wm;
    mm_in         = mm;
    alu_result_in = alu;
    mem_data_in   = wdata;
    reg_dest_in   = dest;
    reg_write_in  = rw;
    wbs_in        = wbs;
  endtask

  int reqs;
  int pulses;

  initial begin
    rst         = 1'b1;
    mem_ack_i   = 1'b0;
    mem_rdata_i = '0;
    idle_inputs();
    tick();
    tick();
    check("rst_wb_valid", wb_valid_o, 0);
    check("rst_req", mem_req_o, 0);
    check("rst_stall", stall_o, 0);
    check("rst_err", mem_err_o, 0);
    check("rst_wb_data", wb_data_o, 0);
    check("rst_addr", mem_addr_o, 0);
    rst = 1'b0;

    // Non-memory instruction: one-cycle latency, never stalls.
    drive(1'b0, 2'b00, 16'h1234, 16'h0000, 4'd3, 1'b1, 1'b1);
    #1 check("nm_stall", stall_o, 0);
    tick();
    idle_inputs();
    check("nm_valid", wb_valid_o, 1);
    check("nm_data", wb_data_o, 16'h1234);
    check("nm_dest", wb_reg_dest_o, 3);
    check("nm_rw", wb_reg_write_o, 1);
    check("nm_wbs", wb_wbs_o, 1);
    check("nm_stall2", stall_o, 0);
    tick();
    check("nm_pulse_end", wb_valid_o, 0);
    check("nm_hold", wb_data_o, 16'h1234);

    // Load acked in its third request cycle.
    drive(1'b0, 2'b01, 16'h0040, 16'h0000, 4'd5, 1'b1, 1'b0);
    #1 check("ld_stall_cap", stall_o, 1);
    check("ld_req_cap", mem_req_o, 0);
    tick();
    reqs = 0;
    for (int c = 1; c <= 3; c++) begin
      if (c == 3) begin
        mem_ack_i   = 1'b1;
        mem_rdata_i = 16'hBEEF;
      end
      #1;
      if (mem_req_o) reqs++;
      check($sformatf("ld_addr_c%0d", c), mem_addr_o, 16'h0040);
      check($sformatf("ld_stall_c%0d", c), stall_o, (c == 3) ? 0 : 1);
      check($sformatf("ld_wbv_c%0d", c), wb_valid_o, 0);
      tick();
    end
    mem_ack_i = 1'b0;
    idle_inputs();
    if (mem_req_o) reqs++;
    check("ld_req_cycles", reqs, 3);
    check("ld_valid", wb_valid_o, 1);
    check("ld_data", wb_data_o, 16'hBEEF);
    check("ld_rw", wb_reg_write_o, 1);
    check("ld_dest", wb_reg_dest_o, 5);
    tick();
    check("ld_pulse_end", wb_valid_o, 0);

    // Store acked in the first request cycle.
    drive(1'b1, 2'b00, 16'h0010, 16'h00AA, 4'd7, 1'b1, 1'b0);
    #1 check("st_stall_cap", stall_o, 1);
    tick();
    check("st_req", mem_req_o, 1);
    check("st_we", mem_we_o, 1);
    check("st_wdata", mem_wdata_o, 16'h00AA);
    check("st_addr", mem_addr_o, 16'h0010);
    mem_ack_i = 1'b1;
    #1 check("st_stall_ack", stall_o, 0);
    tick();
    mem_ack_i = 1'b0;
    idle_inputs();
    check("st_req_drop", mem_req_o, 0);
    check("st_valid", wb_valid_o, 1);
    check("st_rw", wb_reg_write_o, 0);
    check("st_data", wb_data_o, 16'h0010);
    tick();

    // Load that never completes: abandoned after 4 request cycles.
    drive(1'b0, 2'b01, 16'h0080, 16'h0000, 4'd2, 1'b1, 1'b0);
    mem_rdata_i = 16'hDEAD;
    tick();
    idle_inputs();
    reqs = 0;
    for (int c = 0; c < 10; c++) begin
      if (!mem_req_o) break;
      reqs++;
      tick();
    end
    check("to_req_cycles", reqs, 4);
    check("to_req_drop", mem_req_o, 0);
    check("to_valid", wb_valid_o, 1);
    check("to_data", wb_data_o, 0);
    check("to_err", mem_err_o, 1);
    drive(1'b0, 2'b00, 16'h5555, 16'h0000, 4'd9, 1'b1, 1'b0);
    tick();
    idle_inputs();
    check("to_next_data", wb_data_o, 16'h5555);
    check("to_err_sticky", mem_err_o, 1);
    tick();

    // Reset during the second request cycle; a late ack must be ignored.
    drive(1'b0, 2'b01, 16'h0100, 16'h0000, 4'd4, 1'b1, 1'b0);
    tick();
    idle_inputs();
    tick();
    check("rs_req_before", mem_req_o, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rs_req", mem_req_o, 0);
    check("rs_stall", stall_o, 0);
    check("rs_valid", wb_valid_o, 0);
    check("rs_err_clr", mem_err_o, 0);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 16'hCAFE;
    tick();
    mem_ack_i = 1'b0;
    check("rs_late_ack_valid", wb_valid_o, 0);
    check("rs_late_ack_req", mem_req_o, 0);
    check("rs_late_ack_data", wb_data_o, 0);

    // Back-to-back load, non-memory, store; each access acked in its first cycle.
    pulses = 0;
    drive(1'b0, 2'b01, 16'h0200, 16'h0000, 4'd1, 1'b1, 1'b0);
    tick();
    pulses += int'(wb_valid_o);
    mem_ack_i   = 1'b1;
    mem_rdata_i = 16'h1111;
    tick();
    mem_ack_i = 1'b0;
    pulses += int'(wb_valid_o);
    check("bb_ld_data", wb_data_o, 16'h1111);
    check("bb_ld_dest", wb_reg_dest_o, 1);
    drive(1'b0, 2'b00, 16'h2222, 16'h0000, 4'd2, 1'b1, 1'b1);
    tick();
    pulses += int'(wb_valid_o);
    check("bb_nm_data", wb_data_o, 16'h2222);
    check("bb_nm_dest", wb_reg_dest_o, 2);
    drive(1'b1, 2'b00, 16'h0300, 16'h3333, 4'd3, 1'b1, 1'b0);
    #1 check("bb_st_stall", stall_o, 1);
    tick();
    pulses += int'(wb_valid_o);
    check("bb_st_wdata", mem_wdata_o, 16'h3333);
    mem_ack_i = 1'b1;
    tick();
    mem_ack_i = 1'b0;
    idle_inputs();
    pulses += int'(wb_valid_o);
    check("bb_st_data", wb_data_o, 16'h0300);
    check("bb_st_rw", wb_reg_write_o, 0);
    tick();
    pulses += int'(wb_valid_o);
    check("bb_pulses", pulses, 3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
- Consumes the execute/memory pipeline-register outputs and performs the Memory stage of the 16-bit CPU pipeline.
- Drives a request/acknowledge data-memory port for loads and stores.
- Stalls the upstream pipeline while an access is outstanding.
- Presents registered results (data, destination register, writeback controls) to the memory/writeback register.

Parameters:
- DATA_W, 16, data and address width.
- REG_W, 4, destination register index width.
- TIMEOUT, 64, ACCESS cycles without mem_ack_i before the access is abandoned; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ex_valid_in  in  1  execute/memory register holds a valid instruction.
- wbs_in  in  1  writeback select, passed through.
- mm_in  in  2  memory mode: 00 none, 01 load, 10/11 reserved (treated as none).
- wm_in  in  1  store enable; has priority over mm_in.
- reg_write_in  in  1  instruction writes the register file.
- alu_result_in  in  DATA_W  ALU result; this is the memory address for loads/stores.
- mem_data_in  in  DATA_W  store data.
- reg_dest_in  in  REG_W  destination register index.
- stall_o  out  1  hold the execute/memory register and earlier stages.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  request is a store.
- mem_addr_o  out  DATA_W  request address.
- mem_wdata_o  out  DATA_W  store data.
- mem_rdata_i  in  DATA_W  load data, valid with mem_ack_i.
- mem_ack_i  in  1  single-cycle completion pulse.
- wb_valid_o  out  1  result valid for the memory/writeback register (one-cycle pulse per instruction).
- wb_data_o  out  DATA_W  load data or ALU result.
- wb_reg_dest_o  out  REG_W  destination index.
- wb_reg_write_o  out  1  register-file write enable.
- wb_wbs_o  out  1  writeback select.
- mem_err_o  out  1  sticky timeout flag.

Behaviour:
- Reset, synchronous active-high: state IDLE, counter 0. All outputs 0, including mem_err_o.
- Reset mid-access drops mem_req_o at that edge. The abandoned request is discarded; the memory must tolerate this.
- Access classification, only when ex_valid_in=1:
  - store if wm_in=1;
  - else load if mm_in=01;
  - else non-memory.
- FSM states: IDLE, ACCESS.
- IDLE, non-memory instruction:
  - next edge: wb_valid_o=1, wb_data_o=alu_result_in, other wb_* fields copied from inputs; latency 1.
  - stall_o stays 0.
- IDLE, load/store:
  - stall_o=1 combinationally in the same cycle.
  - Latch address, wdata, we, reg_dest, reg_write, wbs.
  - Go to ACCESS; wb_valid_o=0 next cycle.
- ACCESS:
  - mem_req_o=1. mem_addr_o, mem_we_o and mem_wdata_o come from the latches and are stable until ack.
  - Counter increments each cycle.
  - stall_o = !mem_ack_i (combinational), so the upstream register advances on the ack edge.
- ACCESS with mem_ack_i=1, next edge:
  - return to IDLE; wb_valid_o=1, mem_req_o=0.
  - Load: wb_data_o=mem_rdata_i, wb_reg_write_o = latched reg_write.
  - Store: wb_data_o = latched address, wb_reg_write_o=0.
- Timeout (counter reaches TIMEOUT-1 without ack):
  - treated as an ack, except wb_data_o=0 for loads and mem_err_o is set.
  - mem_err_o stays set until rst.
- Miscellaneous:
  - mem_ack_i outside ACCESS is ignored.
  - Ack in the first ACCESS cycle is legal (minimum load latency 2 cycles after IDLE capture).
  - ex_valid_in=0 in IDLE: wb_valid_o=0 next cycle; other wb_* hold.
  - wb_* fields are registered and hold their value when wb_valid_o=0.

Decomposition:
- Package cpu_mem_pkg holds:
  - mm encoding constants (MM_NONE=2'b00, MM_LOAD=2'b01);
  - the state enum mem_state_t {IDLE, ACCESS};
  - the default TIMEOUT.
- One sub-module, mem_timeout_counter: counter with clear/enable, expired flag at TIMEOUT-1, synchronous reset.

Test Plan:
- Non-memory: alu_result_in=16'h1234, reg_dest_in=3, reg_write_in=1, ex_valid_in=1 -> next cycle wb_valid_o=1, wb_data_o=16'h1234, wb_reg_dest_o=3; stall_o never 1.
- Load, ack after 3 cycles with mem_rdata_i=16'hBEEF, address 16'h0040:
  - stall_o=1 from the capture cycle until the ack cycle;
  - mem_req_o=1 with mem_addr_o=16'h0040 for exactly 3 cycles;
  - wb_data_o=16'hBEEF, wb_reg_write_o=1 the cycle after ack.
- Store addr 16'h0010, data 16'h00AA, ack in first ACCESS cycle -> mem_we_o=1, mem_wdata_o=16'h00AA, one req cycle; then wb_valid_o=1, wb_reg_write_o=0.
- Load with no ack, TIMEOUT=4:
  - mem_req_o high for 4 cycles, then drops;
  - wb_data_o=0, mem_err_o=1 and remains 1 through following instructions until rst.
- rst asserted in the second ACCESS cycle -> next cycle mem_req_o=0, stall_o=0, wb_valid_o=0; a later ack is ignored.
- Back-to-back load, non-memory, store, each acked after 1 cycle -> three wb_valid_o pulses in order with correct data; no instruction lost or duplicated.
